trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Multi-cycle trap sequencer between the interrupt-acceptance logic and the CSR file / fetch unit.
//  - Entry (ECALL, external/software/timer IRQ): stalls the pipeline, writes mepc, mcause, mstatus
//    over the single CSR write port, then redirects fetch to the vector address.
//  - Exit (MRET): restores mstatus, then redirects fetch to mepc.
//  - Owns the CSR write port only while busy; the core's own CSR writes are muxed in when idle.
// PARAMETERS
//  ADDR_W    32      PC / vector address width
//  DATA_W    32      CSR data width
//  CSR_MSTATUS 12'h300, CSR_MEPC 12'h341, CSR_MCAUSE 12'h342   CSR write addresses
// PORTS
//  clk_i           in   1       clock, all state on rising edge
//  rst_ni          in   1       asynchronous active-low reset
//  trap_req_i      in   1       trap request (level, held by requester until trap_ack_o)
//  trap_kind_i     in   2       0=ECALL 1=MRET 2=async IRQ 3=reserved(ignored)
//  irq_src_i       in   3       one-hot {ext,tmr,sw}; valid with kind=2
//  vec_addr_i      in   ADDR_W  target address (mtvec-selected vector or mepc for MRET)
//  pc_i            in   ADDR_W  PC of the instruction in decode
//  mstatus_i       in   DATA_W  current mstatus
//  core_csr_we_i   in   1       core CSR write request (passed through when idle)
//  core_csr_addr_i in   12      core CSR write address
//  core_csr_data_i in   DATA_W  core CSR write data
//  csr_we_o        out  1       CSR write enable
//  csr_addr_o      out  12      CSR write address
//  csr_data_o      out  DATA_W  CSR write data
//  stall_o         out  1       freeze IF/ID/EX
//  flush_o         out  1       kill IF/ID contents, one cycle
//  jump_o          out  1       fetch redirect strobe, one cycle
//  jump_addr_o     out  ADDR_W  redirect target
//  trap_ack_o      out  1       request consumed, one cycle
//  busy_o          out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; captured vec/pc/cause/mstatus registers 0.
//  - States: IDLE, W_MEPC, W_CAUSE, W_STAT, M_STAT, JUMP.
//  - IDLE: trap_req_i=1 with kind 0/2 -> W_MEPC; kind 1 -> M_STAT; kind 3 -> stay IDLE, no ack.
//    Accepting cycle: trap_ack_o=1; vec_addr_i, pc_i, mstatus_i, cause captured into registers.
//  - Cause: ECALL 32'd11; IRQ priority ext>sw>tmr -> 32'h8000000B / 32'h80000003 / 32'h80000007.
//    IRQ with irq_src_i==0 -> treated as kind 3 (ignored).
//  - mepc value: ECALL -> captured pc; IRQ -> captured pc (instruction not executed, retried on MRET).
//  - W_MEPC / W_CAUSE / W_STAT: csr_we_o=1 with MEPC / MCAUSE / MSTATUS, one cycle each, in order.
//  - Entry mstatus: MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11, other bits from captured copy.
//  - M_STAT: writes mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b11.
//  - JUMP: jump_o=1, flush_o=1, jump_addr_o=captured vec; next state IDLE.
//  - stall_o=1 from the accepting cycle through JUMP inclusive; 0 in IDLE otherwise.
//  - Latency request->jump_o: entry 4 cycles, MRET 2 cycles. Back-to-back request: accepted the
//    cycle after JUMP (IDLE) at the earliest.
//  - trap_req_i while busy: ignored, no ack. Core CSR writes while busy: dropped; core is stalled,
//    so none are legal. Idle: csr_* = core_csr_* combinationally.
//  - Outputs csr_*, jump_*, flush_o, stall_o registered-state decoded; no combinational path from
//    trap_req_i to csr_we_o.
//  - Async reset mid-sequence: immediate return to IDLE, outputs 0, partial CSR writes not undone.
// CONFIGURATION
//  TRAP_CTRL_PERF_EN defined: adds outputs trap_cnt_o[31:0] and mret_cnt_o[31:0]; each increments
//    once per accepted entry / MRET at the ack cycle, saturating at 32'hFFFF_FFFF, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 ECALL, pc_i=0x100, vec=0x800, mstatus=0x8 -> writes mepc=0x100, mcause=11, mstatus=0x1880;
//    jump_o at cycle 4 to 0x800; stall_o high cycles 0-4.
//  2 MRET, vec=0x104, mstatus=0x1880 -> mstatus write 0x1888 cycle 1; jump_o cycle 2 to 0x104.
//  3 irq_src_i=3'b111 kind=2 -> mcause=0x8000000B; irq_src_i=3'b010 -> 0x80000007.
//  4 Second trap_req_i held during W_CAUSE -> no ack until IDLE; then accepted, sequence repeats.
//  5 rst_ni low during W_CAUSE -> all outputs 0 async; after release IDLE, new ECALL completes.
//  6 Idle core_csr_we_i=1 addr 0x305 data 0x40 -> csr_* mirror same cycle; kind=3 -> no ack, no write.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: multi-cycle trap entry / MRET sequencer that owns the CSR write port while busy.
// Optional event counters (trap_cnt_o, mret_cnt_o) are built when TRAP_CTRL_PERF_EN is defined.
module trap_ctrl #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              trap_req_i,
  input  logic [1:0]        trap_kind_i,
  input  logic [2:0]        irq_src_i,
  input  logic [ADDR_W-1:0] vec_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] mstatus_i,
  input  logic              core_csr_we_i,
  input  logic [11:0]       core_csr_addr_i,
  input  logic [DATA_W-1:0] core_csr_data_i,
  output logic              csr_we_o,
  output logic [11:0]       csr_addr_o,
  output logic [DATA_W-1:0] csr_data_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              trap_ack_o,
  output logic              busy_o
`ifdef TRAP_CTRL_PERF_EN
  ,
  output logic [31:0]       trap_cnt_o,
  output logic [31:0]       mret_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_MEPC  = 3'd1,
    ST_W_CAUSE = 3'd2,
    ST_W_STAT  = 3'd3,
    ST_M_STAT  = 3'd4,
    ST_JUMP    = 3'd5
  } state_e;

  localparam logic [1:0] KIND_ECALL = 2'd0;
  localparam logic [1:0] KIND_MRET  = 2'd1;
  localparam logic [1:0] KIND_IRQ   = 2'd2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] mstat_q, mstat_d;
  logic              accept_s;
  logic              accept_entry_s;
  logic              accept_mret_s;

  // Exception code with interrupt flag; IRQ priority is ext > sw > tmr.
  function automatic logic [DATA_W-1:0] cause_of(input logic [1:0] kind, input logic [2:0] irq);
    logic [31:0] c;
    if (kind == KIND_ECALL) begin
      c = 32'd11;
    end else if (irq[2]) begin
      c = 32'h8000_000B;
    end else if (irq[0]) begin
      c = 32'h8000_0003;
    end else begin
      c = 32'h8000_0007;
    end
    return DATA_W'(c);
  endfunction

  function automatic logic [DATA_W-1:0] mstatus_entry(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mstatus_exit(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Request qualification; reserved kind and IRQ without a source are ignored.
  always_comb begin
    accept_entry_s = 1'b0;
    accept_mret_s  = 1'b0;
    if (rst_ni && (state_q == ST_IDLE) && trap_req_i) begin
      accept_entry_s = (trap_kind_i == KIND_ECALL) ||
                       ((trap_kind_i == KIND_IRQ) && (irq_src_i != 3'b000));
      accept_mret_s  = (trap_kind_i == KIND_MRET);
    end else begin
      accept_entry_s = 1'b0;
      accept_mret_s  = 1'b0;
    end
    accept_s = accept_entry_s | accept_mret_s;
  end

  // Next-state, capture registers and output decode.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    mstat_d     = mstat_q;
    csr_we_o    = 1'b0;
    csr_addr_o  = 12'h000;
    csr_data_o  = '0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    trap_ack_o  = 1'b0;
    busy_o      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (rst_ni) begin
          csr_we_o   = core_csr_we_i;
          csr_addr_o = core_csr_addr_i;
          csr_data_o = core_csr_data_i;
        end else begin
          csr_we_o   = 1'b0;
        end
        if (accept_s) begin
          trap_ack_o = 1'b1;
          stall_o    = 1'b1;
          vec_d      = vec_addr_i;
          pc_d       = pc_i;
          cause_d    = cause_of(trap_kind_i, irq_src_i);
          // The mstatus image to write is fixed at acceptance time.
          mstat_d    = accept_mret_s ? mstatus_exit(mstatus_i) : mstatus_entry(mstatus_i);
          state_d    = accept_mret_s ? ST_M_STAT : ST_W_MEPC;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_W_MEPC: begin
        stall_o    = 1'b1;
        csr_we_o   = 1'b1;
        csr_addr_o = CSR_MEPC;
        csr_data_o = DATA_W'(pc_q);
        state_d    = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        stall_o    = 1'b1;
        csr_we_o   = 1'b1;
        csr_addr_o = CSR_MCAUSE;
        csr_data_o = cause_q;
        state_d    = ST_W_STAT;
      end
      ST_W_STAT, ST_M_STAT: begin
        stall_o    = 1'b1;
        csr_we_o   = 1'b1;
        csr_addr_o = CSR_MSTATUS;
        csr_data_o = mstat_q;
        state_d    = ST_JUMP;
      end
      ST_JUMP: begin
        stall_o     = 1'b1;
        jump_o      = 1'b1;
        flush_o     = 1'b1;
        jump_addr_o = vec_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-operand registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      pc_q    <= '0;
      cause_q <= '0;
      mstat_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mstat_q <= mstat_d;
    end
  end

`ifdef TRAP_CTRL_PERF_EN
  logic [31:0] trap_cnt_q, trap_cnt_d;
  logic [31:0] mret_cnt_q, mret_cnt_d;

  // Saturating event counters, bumped in the acknowledge cycle.
  always_comb begin
    trap_cnt_d = trap_cnt_q;
    mret_cnt_d = mret_cnt_q;
    if (accept_entry_s && (trap_cnt_q != 32'hFFFF_FFFF)) begin
      trap_cnt_d = trap_cnt_q + 32'd1;
    end else begin
      trap_cnt_d = trap_cnt_q;
    end
    if (accept_mret_s && (mret_cnt_q != 32'hFFFF_FFFF)) begin
      mret_cnt_d = mret_cnt_q + 32'd1;
    end else begin
      mret_cnt_d = mret_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trap_cnt_q <= 32'd0;
      mret_cnt_q <= 32'd0;
    end else begin
      trap_cnt_q <= trap_cnt_d;
      mret_cnt_q <= mret_cnt_d;
    end
  end

  assign trap_cnt_o = trap_cnt_q;
  assign mret_cnt_o = mret_cnt_q;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected port events, a monitor pops and compares.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        trap_req_i;
  logic [1:0]  trap_kind_i;
  logic [2:0]  irq_src_i;
  logic [31:0] vec_addr_i, pc_i, mstatus_i;
  logic        core_csr_we_i;
  logic [11:0] core_csr_addr_i;
  logic [31:0] core_csr_data_i;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic        stall_o, flush_o, jump_o, trap_ack_o, busy_o;
  logic [31:0] jump_addr_o;

  trap_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trap_req_i(trap_req_i), .trap_kind_i(trap_kind_i),
    .irq_src_i(irq_src_i), .vec_addr_i(vec_addr_i), .pc_i(pc_i), .mstatus_i(mstatus_i),
    .core_csr_we_i(core_csr_we_i), .core_csr_addr_i(core_csr_addr_i),
    .core_csr_data_i(core_csr_data_i), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .trap_ack_o(trap_ack_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    int          typ;   // 0 ack, 1 csr write, 2 jump
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  bit  stall_exp[int];
  bit  busy_exp[int];
  int  cyc = 0;
  int  free_cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic obs(input int typ, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: cycle %0d type %0d addr %h data %h, nothing expected",
               cyc, typ, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("event", {32'(cyc), 32'(typ), addr, data}, {32'(e.cyc), 32'(e.typ), e.addr, e.data});
    end
  endtask

  // Monitor: per-cycle stall/busy levels plus every ack, CSR write and redirect.
  always @(negedge clk_i) begin
    check("stall", {127'd0, stall_o}, {127'd0, stall_exp.exists(cyc)});
    check("busy", {127'd0, busy_o}, {127'd0, busy_exp.exists(cyc)});
    if (trap_ack_o) obs(0, 32'd0, 32'd0);
    if (csr_we_o) obs(1, {20'd0, csr_addr_o}, csr_data_o);
    if (jump_o || flush_o) obs(2, jump_addr_o, {30'd0, flush_o, jump_o});
  end

  function automatic ev_t mk(input int c, input int t, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.typ = t; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic logic [31:0] ref_cause(input logic [1:0] k, input logic [2:0] irq);
    if (k == 2'd0) return 32'd11;
    if (irq[2]) return 32'h8000_000B;
    if (irq[0]) return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  function automatic logic [31:0] ref_entry(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (((ms >> 3) & 32'd1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ref_exit(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (((ms >> 7) & 32'd1) << 3) | 32'h0000_1880;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    core_csr_we_i = 1'b0;
  endtask

  task automatic idle_cycle(input bit rnd_write);
    step();
    trap_req_i  = 1'b0;
    trap_kind_i = 2'($urandom_range(0, 3));
    if (rnd_write && cyc >= free_cyc && $urandom_range(0, 9) < 3) begin
      core_csr_we_i   = 1'b1;
      core_csr_addr_i = 12'($urandom);
      core_csr_data_i = $urandom;
      exp_q.push_back(mk(cyc, 1, {20'd0, core_csr_addr_i}, core_csr_data_i));
    end
  endtask

  task automatic core_write(input logic [11:0] a, input logic [31:0] d);
    step();
    trap_req_i = 1'b0;
    while (cyc < free_cyc) step();
    core_csr_we_i   = 1'b1;
    core_csr_addr_i = a;
    core_csr_data_i = d;
    exp_q.push_back(mk(cyc, 1, {20'd0, a}, d));
  endtask

  // Issue one request after dly idle cycles; the request is held until the model's acceptance cycle.
  task automatic issue(input logic [1:0] k, input logic [2:0] irq, input logic [31:0] pc,
                       input logic [31:0] vec, input logic [31:0] ms, input int dly, input bit abort);
    int s, a, len;
    bit valid;
    for (int i = 0; i < dly; i++) idle_cycle(1'b1);
    step();
    trap_req_i = 1'b1; trap_kind_i = k; irq_src_i = irq;
    pc_i = pc; vec_addr_i = vec; mstatus_i = ms;
    s = cyc;
    valid = (k == 2'd0) || (k == 2'd1) || (k == 2'd2 && irq != 3'b000);
    if (!valid) begin
      len = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) step();
      return;
    end
    a = (s > free_cyc) ? s : free_cyc;
    exp_q.push_back(mk(a, 0, 32'd0, 32'd0));
    if (k == 2'd1) begin
      exp_q.push_back(mk(a + 1, 1, 32'h300, ref_exit(ms)));
      exp_q.push_back(mk(a + 2, 2, vec, 32'd3));
      len = 2;
    end else if (abort) begin
      exp_q.push_back(mk(a + 1, 1, 32'h341, pc));
      len = 1;
    end else begin
      exp_q.push_back(mk(a + 1, 1, 32'h341, pc));
      exp_q.push_back(mk(a + 2, 1, 32'h342, ref_cause(k, irq)));
      exp_q.push_back(mk(a + 3, 1, 32'h300, ref_entry(ms)));
      exp_q.push_back(mk(a + 4, 2, vec, 32'd3));
      len = 4;
    end
    for (int i = 0; i <= len; i++) begin
      stall_exp[a + i] = 1'b1;
      if (i > 0) busy_exp[a + i] = 1'b1;
    end
    free_cyc = a + len + 1;
    while (cyc < a) step();
    if (abort) begin
      step(); trap_req_i = 1'b0;
      step();
      #1 rst_ni = 1'b0;
      #2 check("reset_outputs",
               {55'd0, csr_we_o, csr_addr_o, csr_data_o, stall_o, flush_o, jump_o, jump_addr_o,
                trap_ack_o, busy_o}, 128'd0);
      step();
      rst_ni   = 1'b1;
      free_cyc = cyc;
    end
  endtask

  initial begin
    rst_ni = 1'b0; trap_req_i = 1'b0; trap_kind_i = 2'd0; irq_src_i = 3'd0;
    vec_addr_i = 32'd0; pc_i = 32'd0; mstatus_i = 32'd0;
    core_csr_we_i = 1'b0; core_csr_addr_i = 12'd0; core_csr_data_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 check("reset_state",
             {55'd0, csr_we_o, csr_addr_o, csr_data_o, stall_o, flush_o, jump_o, jump_addr_o,
              trap_ack_o, busy_o}, 128'd0);
    rst_ni = 1'b1;

    issue(2'd0, 3'b000, 32'h100, 32'h800, 32'h8, 2, 1'b0);
    issue(2'd1, 3'b000, 32'h0, 32'h104, 32'h1880, 2, 1'b0);
    issue(2'd2, 3'b111, 32'h200, 32'h900, 32'h0, 2, 1'b0);
    issue(2'd2, 3'b010, 32'h204, 32'h904, 32'h8, 2, 1'b0);
    issue(2'd2, 3'b001, 32'h208, 32'h908, 32'h88, 1, 1'b0);
    core_write(12'h305, 32'h40);
    issue(2'd3, 3'b000, 32'h300, 32'h500, 32'h8, 2, 1'b0);
    issue(2'd2, 3'b000, 32'h300, 32'h500, 32'h8, 2, 1'b0);
    issue(2'd0, 3'b000, 32'h400, 32'h800, 32'h8, 0, 1'b0);
    issue(2'd0, 3'b000, 32'h404, 32'h804, 32'h0, 0, 1'b0);
    issue(2'd1, 3'b000, 32'h0, 32'h408, 32'h80, 0, 1'b0);
    issue(2'd0, 3'b000, 32'h500, 32'hA00, 32'h8, 2, 1'b1);
    issue(2'd0, 3'b000, 32'h600, 32'hB00, 32'h8, 1, 1'b0);

    for (int t = 0; t < 250; t++) begin
      logic [2:0] irq;
      irq = ($urandom_range(0, 1) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      issue(2'($urandom_range(0, 3)), irq, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), 1'b0);
    end

    for (int i = 0; i < 10; i++) idle_cycle(1'b0);
    @(negedge clk_i);
    #1 check("drain", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
